alu_input_seq: RTL and testbench

Operand-entry sequencer sitting directly upstream of the 4-bit ALU. It takes a 4-bit switch bank and one raw push button. It debounces the button and steps through A → B → op capture on successive presses. It then presents the held operands and opcode to the ALU with a `valid` flag. This turns the ALU's free-running switch inputs into a stable, one-value-at-a-time entry flow.

---
 rtl/alu_seq_pkg.sv | 6 +
 rtl/btn_debounce.sv | 39 +++
 rtl/alu_input_seq.sv | 82 ++++++++
 tb/tb_alu_input_seq.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared operand/opcode widths and stage encoding for the ALU entry sequencer
package alu_seq_pkg;
  localparam int DATA_W = 4;
  localparam int OP_W = 3;
  typedef enum logic [1:0] {S_A = 2'd0, S_B = 2'd1, S_OP = 2'd2, S_SHOW = 2'd3} stage_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: counter debouncer turning a raw button into a one-cycle press pulse
// Ports: clk, rst_n (async active-low), btn (raw button), press (one cycle per accepted 0->1)
// Macro ALU_SEQ_BTN_SYNC_EN: when defined, btn passes through a two-flop synchronizer first
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic bs;
  logic lvl;
  logic hit;
  logic [CNT_W-1:0] cnt;
`ifdef ALU_SEQ_BTN_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= '0;
    else sync <= {sync[0], btn};
  assign bs = sync[1];
`else
  assign bs = btn;
`endif
  // the change has now been seen on DEBOUNCE_CYCLES consecutive edges, so the counter never passes LAST
  assign hit = (bs != lvl) && (cnt == LAST);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      lvl <= 1'b0;
      press <= 1'b0;
    end else begin
      cnt <= (bs != lvl && !hit) ? cnt + 1'b1 : '0;
      lvl <= lvl ^ hit;
      press <= hit && bs;
    end
endmodule

// File: rtl/alu_input_seq.sv
// alu_input_seq: debounced A -> B -> op entry sequencer feeding the 4-bit ALU
// Ports: clk, rst_n (async active-low), sw[3:0] switches, btn raw button, clr sync clear;
//        a, b held operands, op held opcode, valid complete entry, stage current FSM state
// Macro ALU_SEQ_BTN_SYNC_EN: enables the button synchronizer inside btn_debounce (+2 cycles latency)
module alu_input_seq
  import alu_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sw,
  input  logic              btn,
  input  logic              clr,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [OP_W-1:0]   op,
  output logic              valid,
  output logic [1:0]        stage
);
  stage_t state, state_n;
  logic press;
  logic [DATA_W-1:0] a_n, b_n;
  logic [OP_W-1:0] op_n;
  logic valid_n;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb (
    .clk(clk),
    .rst_n(rst_n),
    .btn(btn),
    .press(press)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_A;
      a <= '0;
      b <= '0;
      op <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      a <= a_n;
      b <= b_n;
      op <= op_n;
      valid <= valid_n;
    end
  // clr outranks press; it leaves the debouncer alone
  always_comb begin
    state_n = state;
    a_n = a;
    b_n = b;
    op_n = op;
    valid_n = valid;
    if (clr) begin
      state_n = S_A;
      a_n = '0;
      b_n = '0;
      op_n = '0;
      valid_n = 1'b0;
    end else if (press)
      case (state)
        S_A: begin
          a_n = sw;
          state_n = S_B;
        end
        S_B: begin
          b_n = sw;
          state_n = S_OP;
        end
        S_OP: begin
          op_n = sw[OP_W-1:0];
          valid_n = 1'b1;
          state_n = S_SHOW;
        end
        S_SHOW: begin
          valid_n = 1'b0;
          state_n = S_A;
        end
      endcase
  end
  assign stage = state;
endmodule

// File: tb/tb_alu_input_seq.sv
// tb_alu_input_seq: randomized and directed checks of alu_input_seq against a behavioural model
module tb_alu_input_seq;
  localparam int D = 4;
`ifdef ALU_SEQ_BTN_SYNC_EN
  localparam int LAT = D + 2;
`else
  localparam int LAT = D;
`endif
  logic clk = 0, rst_n = 0, btn = 0, clr = 0;
  logic [3:0] sw = 0, a, b;
  logic [2:0] op;
  logic valid;
  logic [1:0] stage;
  int checks = 0, errors = 0;

  alu_input_seq #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn(btn), .clr(clr),
    .a(a), .b(b), .op(op), .valid(valid), .stage(stage)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // model: a level is accepted once the last D samples all disagree with it
  bit win[$];
  bit syncq[$] = '{0, 0};
  bit m_lvl = 0, m_press = 0, m_bs = 0, m_flip = 0;
  int m_stage = 0;
  logic [3:0] m_a = 0, m_b = 0;
  logic [2:0] m_op = 0;
  bit m_valid = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win.delete();
      syncq = '{0, 0};
      m_lvl = 0; m_press = 0; m_stage = 0;
      m_a = 0; m_b = 0; m_op = 0; m_valid = 0;
    end else begin
      if (clr) begin
        m_stage = 0; m_a = 0; m_b = 0; m_op = 0; m_valid = 0;
      end else if (m_press) begin
        if (m_stage == 0) m_a = sw;
        else if (m_stage == 1) m_b = sw;
        else if (m_stage == 2) begin m_op = sw[2:0]; m_valid = 1; end
        else m_valid = 0;
        m_stage = (m_stage + 1) % 4;
      end
`ifdef ALU_SEQ_BTN_SYNC_EN
      syncq.push_back(btn);
      m_bs = syncq.pop_front();
`else
      m_bs = btn;
`endif
      win.push_back(m_bs);
      if (win.size() > D) void'(win.pop_front());
      m_flip = (win.size() == D);
      foreach (win[i]) if (win[i] == m_lvl) m_flip = 0;
      m_press = m_flip && !m_lvl;
      if (m_flip) m_lvl = !m_lvl;
    end
  end

  always @(negedge clk)
    if (rst_n) begin
      chk("a", a, m_a);
      chk("b", b, m_b);
      chk("op", op, m_op);
      chk("valid", valid, m_valid);
      chk("stage", stage, m_stage);
    end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic press_lat(input logic [3:0] v);
    int n;
    logic [1:0] s0;
    sw = v; btn = 1; s0 = stage; n = 0;
    while (n < 50) begin
      @(posedge clk); #1;
      if (stage != s0) break;
      n++;
    end
    chk("cap_lat", n, LAT);
    #1; btn = 0;
    cyc(D + 2);
  endtask

  initial begin
    int adv;
    logic [1:0] prev;
    #12 rst_n = 1;
    cyc(1);
    chk("rst_a", a, 0); chk("rst_b", b, 0); chk("rst_op", op, 0);
    chk("rst_valid", valid, 0); chk("rst_stage", stage, 0);
    cyc(2);
    // full entry
    press_lat(3); press_lat(5); press_lat(0);
    chk("full_a", a, 3); chk("full_b", b, 5); chk("full_op", op, 0);
    chk("full_valid", valid, 1); chk("full_stage", stage, 3);
    // return path
    sw = 15;
    press_lat(15);
    chk("ret_valid", valid, 0); chk("ret_stage", stage, 0);
    chk("ret_a", a, 3); chk("ret_b", b, 5); chk("ret_op", op, 0);
    press_lat(9); press_lat(9); press_lat(7);
    chk("ent2_a", a, 9); chk("ent2_b", b, 9); chk("ent2_op", op, 7);
    chk("ent2_valid", valid, 1);
    press_lat(0);
    // bounce rejection
    sw = 12;
    btn = 1; cyc(1); btn = 0; cyc(1); btn = 1; cyc(1); btn = 0; cyc(1);
    btn = 1; cyc(4); btn = 0; cyc(LAT + 4);
    chk("bounce_stage", stage, 1); chk("bounce_a", a, 12);
    // hold without repeat
    sw = 4; btn = 1; adv = 0; prev = stage;
    repeat (100) begin
      cyc(1);
      if (stage != prev) adv++;
      prev = stage;
    end
    btn = 0; cyc(D + 2);
    chk("hold_adv", adv, 1); chk("hold_b", b, 4); chk("hold_stage", stage, 2);
    // clr on the S_OP capture edge
    sw = 6; btn = 1; cyc(LAT); clr = 1; cyc(1); clr = 0;
    chk("clr_stage", stage, 0); chk("clr_a", a, 0); chk("clr_b", b, 0);
    chk("clr_op", op, 0); chk("clr_valid", valid, 0);
    btn = 0; cyc(D + 2);
    chk("clr_hold_stage", stage, 0);
    // async reset while in S_B
    press_lat(11);
    chk("pre_rst_stage", stage, 1);
    #1 rst_n = 0;
    #1;
    chk("arst_a", a, 0); chk("arst_stage", stage, 0); chk("arst_valid", valid, 0);
    cyc(2); rst_n = 1; cyc(2);
    press_lat(6);
    chk("post_rst_a", a, 6); chk("post_rst_stage", stage, 1);
    // random traffic
    repeat (300) begin
      btn = 1'($urandom_range(0, 1));
      sw = 4'($urandom);
      clr = ($urandom_range(0, 15) == 0);
      cyc(1);
      clr = 0;
      cyc($urandom_range(0, 6));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
